// File: rtl/spi_slave_tester.sv
// spi_slave_tester: arithmetic tx sequence source and per-transfer rx statistics for an SPI slave
module spi_slave_tester #(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      next,
  input  logic                      stop,
  input  logic [DATA_BUS_WIDTH-1:0] din,
  input  logic [5:0]                sym_size,
  input  logic [DATA_BUS_WIDTH-1:0] tx_start_value,
  input  logic [DATA_BUS_WIDTH-1:0] tx_increment,
  input  logic                      clear,
  output logic [DATA_BUS_WIDTH-1:0] dout,
  output logic                      active,
  output logic [15:0]               transfer_count,
  output logic [15:0]               last_sym_count,
  output logic [31:0]               last_checksum
);
  localparam int W = DATA_BUS_WIDTH;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  dout_q, dout_d, mask, start_m, first_m;
  logic [15:0]   cnt_q, cnt_d, cnt_nx, tc_q, tc_d, lc_q, lc_d;
  logic [31:0]   sum_q, sum_d, sum_nx, ls_q, ls_d;
  logic          active_q, active_d;
  // symbol mask: a size of 0 or at least the bus width selects the full bus
  always_comb begin
    for (int i = 0; i < W; i++) mask[i] = (sym_size == 6'd0) || (i < int'(sym_size));
  end
  assign start_m = tx_start_value & mask;
  assign first_m = (tx_start_value + tx_increment) & mask;
  assign cnt_nx  = next ? ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1) : cnt_q;
  assign sum_nx  = next ? sum_q + 32'(din & mask) : sum_q;
  // transfer FSM, tx sequence and statistics; clear overrides all stats updates
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tc_d    = tc_q;
    lc_d    = lc_q;
    ls_d    = ls_q;
    if (state_q == IDLE) begin
      dout_d = start_m;
      if (start) begin
        state_d = ACTIVE;
        dout_d  = first_m;
        cnt_d   = '0;
        sum_d   = '0;
      end
    end else if (start) begin
      dout_d = first_m;
      cnt_d  = '0;
      sum_d  = '0;
    end else if (stop) begin
      state_d = IDLE;
      dout_d  = start_m;
      lc_d    = cnt_nx;
      ls_d    = sum_nx;
      tc_d    = tc_q + 16'd1;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (next) begin
      dout_d = (dout_q + tx_increment) & mask;
      cnt_d  = cnt_nx;
      sum_d  = sum_nx;
    end
    if (clear) begin
      cnt_d = '0;
      sum_d = '0;
      tc_d  = '0;
      lc_d  = '0;
      ls_d  = '0;
    end
    active_d = (state_d == ACTIVE);
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      tc_q     <= '0;
      lc_q     <= '0;
      ls_q     <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      tc_q     <= tc_d;
      lc_q     <= lc_d;
      ls_q     <= ls_d;
      active_q <= active_d;
    end
  end
  assign dout           = dout_q;
  assign active         = active_q;
  assign transfer_count = tc_q;
  assign last_sym_count = lc_q;
  assign last_checksum  = ls_q;
endmodule

// File: tb/tb_spi_slave_tester.sv
// tb_spi_slave_tester: scoreboard bench for spi_slave_tester
module tb_spi_slave_tester;
  typedef struct {
    logic [15:0] cnt;
    logic [31:0] sum;
    logic [15:0] tc;
  } stat_t;
  logic        clk = 1'b0;
  logic        rst, start, next, stop, clear;
  logic [7:0]  din, tx_start_value, tx_increment, dout;
  logic [5:0]  sym_size;
  logic        active;
  logic [15:0] transfer_count, last_sym_count;
  logic [31:0] last_checksum;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  dq[$];
  stat_t       sq[$];
  spi_slave_tester #(.DATA_BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .next(next), .stop(stop), .din(din),
    .sym_size(sym_size), .tx_start_value(tx_start_value), .tx_increment(tx_increment),
    .clear(clear), .dout(dout), .active(active), .transfer_count(transfer_count),
    .last_sym_count(last_sym_count), .last_checksum(last_checksum)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic s, input logic n, input logic p, input logic c, input logic [7:0] d);
    start = s;
    next  = n;
    stop  = p;
    clear = c;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    next  = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    din   = 8'h00;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; next = 1'b0; stop = 1'b0; clear = 1'b0; din = 8'h00;
    sym_size = 6'd8; tx_start_value = 8'h10; tx_increment = 8'h01;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dout, active, transfer_count, last_sym_count, last_checksum} !== 65'd0) begin
      failures++;
      $display("FAIL reset_outputs got dout=%h act=%b tc=%h lc=%h ls=%h exp all 0", dout, active, transfer_count, last_sym_count, last_checksum);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dout !== 8'h10) begin
      failures++;
      $display("FAIL reset_idle_dout got=%h exp=10", dout);
    end
  endtask
  task automatic test_basic;
    logic [7:0] e;
    stat_t s;
    for (int i = 0; i < 6; i++) dq.push_back(8'h10 + 8'(i));
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL basic_dout0 got=%h exp=%h", dout, e); end
    drive(1, 0, 0, 0, 8'h00);
    e = dq.pop_front();
    checks++;
    if (dout !== e || active !== 1'b1) begin failures++; $display("FAIL basic_start got dout=%h act=%b exp dout=%h act=1", dout, active, e); end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 0, 0, 8'(i));
      e = dq.pop_front();
      checks++;
      if (dout !== e) begin failures++; $display("FAIL basic_dout%0d got=%h exp=%h", i, dout, e); end
    end
    sq.push_back('{16'd4, 32'h0A, 16'd1});
    drive(0, 0, 1, 0, 8'h00);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc || dout !== 8'h10 || active !== 1'b0)
      begin failures++; $display("FAIL basic_stats got lc=%h ls=%h tc=%h dout=%h act=%b exp lc=%h ls=%h tc=%h dout=10 act=0",
        last_sym_count, last_checksum, transfer_count, dout, active, s.cnt, s.sum, s.tc); end
  endtask
  task automatic test_wrap;
    logic [7:0] e;
    stat_t s;
    sym_size = 6'd4; tx_start_value = 8'h0E; tx_increment = 8'h03;
    dq.push_back(8'h0E); dq.push_back(8'h01); dq.push_back(8'h04); dq.push_back(8'h07);
    drive(0, 0, 0, 0, 8'h00);
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL wrap_idle got=%h exp=%h", dout, e); end
    drive(1, 0, 0, 0, 8'h00);
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL wrap_start got=%h exp=%h", dout, e); end
    drive(0, 1, 0, 0, 8'hFF);
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL wrap_next1 got=%h exp=%h", dout, e); end
    drive(0, 1, 0, 0, 8'h01);
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL wrap_next2 got=%h exp=%h", dout, e); end
    sq.push_back('{16'd2, 32'h10, 16'd2});
    drive(0, 0, 1, 0, 8'h00);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc || dout !== 8'h0E)
      begin failures++; $display("FAIL wrap_stats got lc=%h ls=%h tc=%h dout=%h exp lc=%h ls=%h tc=%h dout=0e",
        last_sym_count, last_checksum, transfer_count, dout, s.cnt, s.sum, s.tc); end
    sym_size = 6'd8; tx_start_value = 8'h10; tx_increment = 8'h01;
    drive(0, 0, 0, 0, 8'h00);
  endtask
  task automatic test_coincident;
    stat_t s;
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h05);
    drive(0, 1, 0, 0, 8'h05);
    sq.push_back('{16'd3, 32'h11, 16'd3});
    drive(0, 1, 1, 0, 8'h07);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc || active !== 1'b0)
      begin failures++; $display("FAIL coincident_stats got lc=%h ls=%h tc=%h act=%b exp lc=%h ls=%h tc=%h act=0",
        last_sym_count, last_checksum, transfer_count, active, s.cnt, s.sum, s.tc); end
  endtask
  task automatic test_restart_clear;
    logic [7:0] e;
    stat_t s;
    drive(0, 0, 0, 1, 8'h00);
    checks++;
    if (transfer_count !== 16'd0 || last_sym_count !== 16'd0) begin failures++; $display("FAIL idle_clear got tc=%h lc=%h exp 0", transfer_count, last_sym_count); end
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h01);
    drive(0, 1, 0, 0, 8'h02);
    dq.push_back(8'h11);
    drive(1, 0, 0, 0, 8'h00);
    e = dq.pop_front();
    checks++;
    if (dout !== e || active !== 1'b1) begin failures++; $display("FAIL restart_dout got dout=%h act=%b exp dout=%h act=1", dout, active, e); end
    drive(0, 1, 0, 0, 8'h09);
    sq.push_back('{16'd1, 32'h09, 16'd1});
    drive(0, 0, 1, 0, 8'h00);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc)
      begin failures++; $display("FAIL restart_stats got lc=%h ls=%h tc=%h exp lc=%h ls=%h tc=%h",
        last_sym_count, last_checksum, transfer_count, s.cnt, s.sum, s.tc); end
    drive(0, 0, 0, 1, 8'h00);
    checks++;
    if (last_sym_count !== 16'd0 || last_checksum !== 32'd0 || transfer_count !== 16'd0 || dout !== 8'h10)
      begin failures++; $display("FAIL clear_stats got lc=%h ls=%h tc=%h dout=%h exp 0 0 0 dout=10",
        last_sym_count, last_checksum, transfer_count, dout); end
    drive(1, 0, 0, 0, 8'h00);
    dq.push_back(8'h12);
    drive(0, 1, 0, 1, 8'h20);
    e = dq.pop_front();
    checks++;
    if (dout !== e) begin failures++; $display("FAIL clear_next_dout got=%h exp=%h", dout, e); end
    drive(0, 1, 0, 0, 8'h03);
    sq.push_back('{16'd1, 32'h03, 16'd1});
    drive(0, 0, 1, 0, 8'h00);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc)
      begin failures++; $display("FAIL clear_next_stats got lc=%h ls=%h tc=%h exp lc=%h ls=%h tc=%h",
        last_sym_count, last_checksum, transfer_count, s.cnt, s.sum, s.tc); end
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h04);
    sq.push_back('{16'd0, 32'h0, 16'd0});
    drive(0, 0, 1, 1, 8'h00);
    s = sq.pop_front();
    checks++;
    if (last_sym_count !== s.cnt || last_checksum !== s.sum || transfer_count !== s.tc || active !== 1'b0)
      begin failures++; $display("FAIL clear_stop_stats got lc=%h ls=%h tc=%h act=%b exp lc=%h ls=%h tc=%h act=0",
        last_sym_count, last_checksum, transfer_count, active, s.cnt, s.sum, s.tc); end
  endtask
  task automatic test_async_reset;
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h01);
    drive(0, 0, 1, 0, 8'h00);
    checks++;
    if (transfer_count !== 16'd1) begin failures++; $display("FAIL pre_reset_tc got=%h exp=1", transfer_count); end
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h01);
    drive(0, 1, 0, 0, 8'h02);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dout, active, transfer_count, last_sym_count, last_checksum} !== 65'd0) begin
      failures++;
      $display("FAIL async_reset got dout=%h act=%b tc=%h lc=%h ls=%h exp all 0", dout, active, transfer_count, last_sym_count, last_checksum);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 0, 8'h00);
    checks++;
    if (transfer_count !== 16'd0 || active !== 1'b0 || last_sym_count !== 16'd0 || dout !== 8'h10)
      begin failures++; $display("FAIL stray_stop got tc=%h act=%b lc=%h dout=%h exp tc=0 act=0 lc=0 dout=10",
        transfer_count, active, last_sym_count, dout); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_coincident();
    test_restart_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
